// File: rtl/upe_bitblink.sv
// Serial bit-display engine: captures a result word and shows it one bit per
// PERIOD cycles on a single LED, with a blank gap, done pulse and auto-repeat.
module upe_bitblink #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned PERIOD    = 1251,
    parameter int unsigned GAP_BITS  = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [WIDTH-1:0]           data,
    input  logic                       sign_en,
    input  logic                       sign,
    input  logic                       repeat_en,
    output logic                       ready,
    output logic                       led,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       frame_done
);

    localparam int unsigned IDX_W   = $clog2(WIDTH);
    localparam int unsigned CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned GAP_TOT = GAP_BITS * PERIOD;
    localparam int unsigned GCNT_W  = (GAP_TOT > 1) ? $clog2(GAP_TOT) : 1;
    localparam bit          HAS_GAP = (GAP_BITS != 0);

    localparam logic [IDX_W-1:0]  FIRST_IDX = MSB_FIRST ? IDX_W'(WIDTH - 1) : IDX_W'(0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = MSB_FIRST ? IDX_W'(0) : IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'((GAP_TOT > 0) ? GAP_TOT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    word;
    logic [CNT_W-1:0]    cnt;
    logic [GCNT_W-1:0]   gcnt;

    logic [WIDTH-1:0]    cap_word_c;
    logic [IDX_W-1:0]    next_idx_c;
    logic                bit_end_c;
    logic                frame_end_c;

    // Captured word with optional sign override of the top bit
    always_comb begin
        cap_word_c = {(sign_en ? sign : data[WIDTH-1]), data[WIDTH-2:0]};
    end

    always_comb begin
        next_idx_c  = MSB_FIRST ? (bit_idx - IDX_W'(1)) : (bit_idx + IDX_W'(1));
        bit_end_c   = (state == ST_SHIFT) && (cnt == CNT_LAST);
        frame_end_c = (bit_end_c && (bit_idx == LAST_IDX) && !HAS_GAP) ||
                      ((state == ST_GAP) && (gcnt == GAP_LAST));
    end

    // Frame sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word       <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            ready      <= 1'b1;
            led        <= 1'b0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_end_c) begin
                // Repeat restarts on the held word in the done cycle itself
                frame_done <= 1'b1;
                cnt        <= '0;
                gcnt       <= '0;
                if (repeat_en) begin
                    state   <= ST_SHIFT;
                    bit_idx <= FIRST_IDX;
                    led     <= word[FIRST_IDX];
                end else begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    led   <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A load coinciding with the done pulse is dropped
                        if (load && !frame_done) begin
                            state   <= ST_SHIFT;
                            word    <= cap_word_c;
                            bit_idx <= FIRST_IDX;
                            led     <= cap_word_c[FIRST_IDX];
                            cnt     <= '0;
                            ready   <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        if (bit_end_c) begin
                            cnt <= '0;
                            if (bit_idx == LAST_IDX) begin
                                state <= ST_GAP;
                                gcnt  <= '0;
                                led   <= 1'b0;
                            end else begin
                                bit_idx <= next_idx_c;
                                led     <= word[next_idx_c];
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        gcnt <= gcnt + GCNT_W'(1);
                    end
                    default: begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        led   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/upe_bitblink.md
# upe_bitblink

Parametrised serial bit-display engine for the iCE40 UPE bring-up boards. It captures a WIDTH-bit result word from a UPE arithmetic unit, optionally overrides its sign bit (sign-magnitude resign), and clocks the word out one bit per PERIOD cycles on a single LED. An inter-frame blank gap, single-cycle completion pulse and optional auto-repeat let a human or logic analyser read results without a UART. It replaces ad-hoc per-bench blink counters. It sits between a UPE unit's output and the board LED pin, driven by the SB_LFOSC clock.

## Interface
- WIDTH, 64, word width in bits (2..64)
- PERIOD, 1251, clk cycles each bit is held on the LED (≥1)
- GAP_BITS, 4, blank bit-periods after each frame (0 = no gap)
- MSB_FIRST, 0, 0: emit bit 0 first; 1: emit bit WIDTH-1 first

- clk  in  1  system clock (10 kHz SB_LFOSC on hardware)
- rst_n  in  1  synchronous active-low reset
- load  in  1  request to capture `data`; accepted only when `ready`=1
- data  in  WIDTH  word to display
- sign_en  in  1  when 1 at capture, bit WIDTH-1 is replaced by `sign`
- sign  in  1  sign value written into bit WIDTH-1 when sign_en=1
- repeat_en  in  1  sampled at end of gap; 1 = replay captured word
- ready  out  1  idle, able to accept load
- led  out  1  registered LED drive
- bit_idx  out  clog2(WIDTH)  index of the bit currently on `led`
- frame_done  out  1  one-cycle pulse at end of each frame (including gap)

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: ready=1, led=0. On load=1, capture word = data, with bit WIDTH-1 = sign if sign_en else data[WIDTH-1]; bit_idx = 0 (LSB-first) or WIDTH-1 (MSB-first); period counter = 0; go SHIFT.
- SHIFT: led = word[bit_idx]. Period counter counts 0..PERIOD-1; at PERIOD-1 advance bit_idx (+1 LSB-first, -1 MSB-first) and clear counter. After the last bit's final cycle go GAP if GAP_BITS>0, else end frame.
- GAP: led=0 for GAP_BITS×PERIOD cycles; bit_idx holds last-emitted index. Then end frame.
- End frame: frame_done=1 for one cycle. If repeat_en=1 in that cycle, restart SHIFT on the held word (no re-capture, ready stays 0); else IDLE.
- load while ready=0 is ignored; data/sign/sign_en changes after capture have no effect.
- Counters sized to PERIOD and GAP_BITS×PERIOD; no wrap beyond their terminal values.
- rst_n=0 at any clock edge, including mid-frame: abort, return to IDLE on that edge.

## Timing
- Reset values: ready=1, led=0, bit_idx=0, frame_done=0, state IDLE, word=0.
- load sampled at edge T → ready=0 and led = first bit from T+1 (one-cycle latency).
- Each bit visible for exactly PERIOD cycles; frame length (WIDTH+GAP_BITS)×PERIOD cycles from T+1.
- frame_done high in the cycle after the last gap (or last bit) cycle; in that same cycle ready=1 (no repeat) or led = first bit again (repeat) — no dead cycle between repeated frames beyond the gap.
- load coincident with frame_done is ignored; load is accepted from the following cycle when ready=1.
- All outputs registered; no combinational input→output paths.

## Test plan
- WIDTH=8, PERIOD=4, GAP_BITS=2, MSB_FIRST=0; load data=8'hA5, sign_en=0 → led holds 1,0,1,0,0,1,0,1 for 4 cycles each from T+1, then 0 for 8 cycles, frame_done pulse at T+41, ready=1 at T+41.
- Same config, data=8'h05, sign_en=1, sign=1 → captured 8'h85; last bit (index 7) shows 1; with sign=0, data=8'hFF → last bit 0.
- MSB_FIRST=1, data=8'h01, GAP_BITS=0 → led 0 for 28 cycles then 1 for 4; bit_idx counts 7→0; frame_done at T+33.
- repeat_en=1, data=8'h3C → second frame starts in frame_done cycle with identical pattern; load=1 pulsed mid-frame with data=8'hFF has no effect; deassert repeat_en → IDLE after current frame.
- rst_n=0 during bit 3 of a frame → next cycle led=0, ready=1, bit_idx=0, frame_done=0; subsequent load works normally.
- PERIOD=1, WIDTH=2, GAP_BITS=0, data=2'b10 → led 0 at T+1, 1 at T+2, frame_done at T+3.
